// File: rtl/plic_gateway.sv
`default_nettype none
// ============================================================================
// Module   : plic_gateway
// Brief    : Per-source interrupt gateway in front of the PLIC: synchronises
//            raw lines, supports level/edge sources, one request per claim.
// Revision : 1.0 - initial release
// ============================================================================
module plic_gateway #(
  parameter int unsigned        SOURCES     = 32,
  parameter int unsigned        SYNC_STAGES = 2,
  parameter logic [SOURCES-1:0] EDGE_MASK   = '0,
  parameter int unsigned        MAX_PENDING = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [SOURCES-1:0] irq_in,
  input  logic [SOURCES-1:0] claim,
  input  logic [SOURCES-1:0] complete,
  output logic [SOURCES-1:0] req,
  output logic [SOURCES-1:0] overflow
);

  localparam int unsigned      CNT_W   = $clog2(MAX_PENDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PENDING);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_PENDING  = 2'd1;
  localparam logic [1:0] ST_INFLIGHT = 2'd2;

  // ID 0 is reserved by the PLIC and never requests.
  assign req[0]      = 1'b0;
  assign overflow[0] = 1'b0;

  logic unused_src0;
  assign unused_src0 = ^{irq_in[0], claim[0], complete[0]};

  for (genvar i = 1; i < SOURCES; i++) begin : g_src
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s_dly_q, s_dly_d;
    logic                   edge_q, edge_d;
    logic [1:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   req_q, req_d;
    logic                   ovf_q, ovf_d;
    logic                   claim_acc;
    logic                   trig;

    assign claim_acc = (state_q == ST_PENDING) && claim[i];

    always_ff @(posedge clk) begin
      if (reset) begin
        sync_q  <= '0;
        s_dly_q <= 1'b0;
        edge_q  <= 1'b0;
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        req_q   <= 1'b0;
        ovf_q   <= 1'b0;
      end else begin
        sync_q  <= sync_d;
        s_dly_q <= s_dly_d;
        edge_q  <= edge_d;
        state_q <= state_d;
        cnt_q   <= cnt_d;
        req_q   <= req_d;
        ovf_q   <= ovf_d;
      end
    end

    // Level and edge both reach the FSM one register after s, so the two
    // modes share the same input latency.
    always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], irq_in[i]};
      s_dly_d = sync_q[SYNC_STAGES-1];
      edge_d  = sync_q[SYNC_STAGES-1] & ~s_dly_q;
    end

    always_comb begin
      state_d = state_q;
      trig    = EDGE_MASK[i] ? (edge_q || (cnt_q != '0)) : s_dly_q;
      case (state_q)
        ST_IDLE:     if (trig)        state_d = ST_PENDING;
        ST_PENDING:  if (claim[i])    state_d = ST_INFLIGHT;
        ST_INFLIGHT: if (complete[i]) state_d = ST_IDLE;
        default:                      state_d = ST_IDLE;
      endcase
    end

    // cnt includes the edge currently presented, so a claim consumes one.
    always_comb begin
      cnt_d = cnt_q;
      ovf_d = 1'b0;
      if (EDGE_MASK[i]) begin
        if (edge_q && !claim_acc) begin
          if (cnt_q == CNT_MAX) ovf_d = 1'b1;
          else                  cnt_d = cnt_q + 1'b1;
        end else if (claim_acc && !edge_q) begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      req_d = (state_d == ST_PENDING);
    end

    assign req[i]      = req_q;
    assign overflow[i] = ovf_q;
  end : g_src

endmodule
`default_nettype wire

// File: tb/tb_plic_gateway.sv
`default_nettype none
// ============================================================================
// Module   : tb_plic_gateway
// Brief    : Directed and randomized checks of plic_gateway against a
//            behavioural request/claim model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_plic_gateway;

  localparam int             NS    = 32;
  localparam int             SYNC  = 2;
  localparam int             MAXP  = 7;
  localparam logic [NS-1:0]  EMASK = 32'hF0F0_00A0;

  logic          clk      = 1'b0;
  logic          reset    = 1'b1;
  logic [NS-1:0] irq_in   = '0;
  logic [NS-1:0] claim    = '0;
  logic [NS-1:0] complete = '0;
  logic [NS-1:0] req;
  logic [NS-1:0] overflow;

  plic_gateway #(
    .SOURCES     (NS),
    .SYNC_STAGES (SYNC),
    .EDGE_MASK   (EMASK),
    .MAX_PENDING (MAXP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .irq_in   (irq_in),
    .claim    (claim),
    .complete (complete),
    .req      (req),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int ov5      = 0;

  // Reference model: irq history (index 0 = previous edge), plus
  // "request visible", "claimed awaiting completion" and queued edge count.
  logic [SYNC+1:0] hist [NS];
  bit              waiting [NS];
  bit              busy [NS];
  int              cnt [NS];
  logic [NS-1:0]   exp_req = '0;
  logic [NS-1:0]   exp_ov  = '0;

  task automatic model_edge(input logic rst, input logic [NS-1:0] irq,
                            input logic [NS-1:0] clm, input logic [NS-1:0] cmp);
    for (int i = 0; i < NS; i++) begin
      bit lvl;
      bit e;
      bit took;
      int old;
      if (rst) begin
        hist[i] = '0; waiting[i] = 0; busy[i] = 0; cnt[i] = 0;
        exp_req[i] = 1'b0; exp_ov[i] = 1'b0;
        continue;
      end
      // Input seen by the gateway logic is irq_in from SYNC+1 edges ago.
      lvl = hist[i][SYNC];
      e   = hist[i][SYNC] & ~hist[i][SYNC+1];
      hist[i] = {hist[i][SYNC:0], irq[i]};
      exp_ov[i] = 1'b0;
      if (i == 0) begin
        exp_req[i] = 1'b0;
        continue;
      end
      took = waiting[i] && clm[i];
      old  = cnt[i];
      if (EMASK[i]) begin
        if (e && !took) begin
          if (cnt[i] == MAXP) exp_ov[i] = 1'b1;
          else                cnt[i] = cnt[i] + 1;
        end else if (took && !e) begin
          cnt[i] = cnt[i] - 1;
        end
      end
      if (took) begin
        waiting[i] = 0;
        busy[i]    = 1;
      end else if (busy[i] && cmp[i]) begin
        busy[i] = 0;
      end else if (!waiting[i] && !busy[i]) begin
        waiting[i] = EMASK[i] ? (old > 0 || e) : lvl;
      end
      exp_req[i] = waiting[i];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(reset, irq_in, claim, complete);
    #1;
    if (overflow[5] === 1'b1) ov5++;
    n_assert++;
    assert (req === exp_req) else begin
      n_fail++;
      $error("FAIL model_req observed=%h expected=%h", req, exp_req);
    end
    n_assert++;
    assert (overflow === exp_ov) else begin
      n_fail++;
      $error("FAIL model_overflow observed=%h expected=%h", overflow, exp_ov);
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int expv);
    n_assert++;
    assert (obs == expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic pulse_claim(input int s);
    claim[s] = 1'b1; tick(); claim[s] = 1'b0;
  endtask

  task automatic pulse_complete(input int s);
    complete[s] = 1'b1; tick(); complete[s] = 1'b0;
  endtask

  task automatic edge_pulses(input int s, input int n);
    repeat (n) begin
      irq_in[s] = 1'b1; tick(); tick();
      irq_in[s] = 1'b0; tick(); tick();
    end
  endtask

  // Acts as the PLIC/target for one source until no request appears in budget.
  task automatic serve(input int s, input int budget, output int rounds);
    int w;
    rounds = 0;
    while (rounds <= 20) begin
      w = 0;
      while (req[s] !== 1'b1 && w < budget) begin
        tick();
        w++;
      end
      if (req[s] !== 1'b1) break;
      pulse_claim(s);
      chk("serve_req_drop", req[s], 1'b0);
      repeat (2) tick();
      pulse_complete(s);
      rounds++;
    end
  endtask

  initial begin
    int r;

    // Reset
    repeat (3) tick();
    chk("reset_req_zero", |req, 1'b0);
    chk("reset_ovf_zero", |overflow, 1'b0);

    // Level source 3: latency, latching, claim, back-to-back gap
    reset = 1'b0;
    irq_in[3] = 1'b1;
    tick(); chk("lvl_lat_e0", req[3], 1'b0);
    tick(); chk("lvl_lat_e1", req[3], 1'b0);
    tick(); chk("lvl_lat_e2", req[3], 1'b0);
    tick(); chk("lvl_lat_e3", req[3], 1'b1);
    irq_in[3] = 1'b0;
    repeat (4) tick();
    chk("lvl_latched", req[3], 1'b1);
    irq_in[3] = 1'b1;
    repeat (4) tick();
    pulse_claim(3);
    chk("lvl_claim_drop", req[3], 1'b0);
    repeat (3) tick();
    chk("lvl_inflight", req[3], 1'b0);
    pulse_complete(3);
    chk("lvl_gap", req[3], 1'b0);
    tick();
    chk("lvl_rearm", req[3], 1'b1);

    // Claim and complete together while pending: complete is discarded
    claim[3] = 1'b1; complete[3] = 1'b1;
    tick();
    claim[3] = 1'b0; complete[3] = 1'b0;
    chk("cc_inflight", req[3], 1'b0);
    repeat (3) tick();
    chk("cc_held", req[3], 1'b0);
    pulse_complete(3);
    tick();
    chk("cc_release", req[3], 1'b1);
    irq_in[3] = 1'b0;
    repeat (4) tick();
    pulse_claim(3);
    pulse_complete(3);
    repeat (4) tick();
    chk("lvl_idle", req[3], 1'b0);

    // Edge source 5: three pulses -> three rounds
    edge_pulses(5, 3);
    serve(5, 20, r);
    chk_int("edge_rounds", r, 3);

    // Saturation: nine unclaimed edges, two lost
    ov5 = 0;
    edge_pulses(5, 9);
    repeat (4) tick();
    chk_int("ovf_pulses", ov5, 2);
    serve(5, 20, r);
    chk_int("ovf_rounds", r, 7);

    // Edge arriving in the same cycle as a claim with two queued
    edge_pulses(5, 2);
    irq_in[5] = 1'b1; tick(); tick();
    irq_in[5] = 1'b0; tick();
    pulse_claim(5);
    chk("sim_claim_drop", req[5], 1'b0);
    repeat (2) tick();
    pulse_complete(5);
    serve(5, 20, r);
    chk_int("sim_rounds", r, 2);

    // Reset while source 7 is in flight with four queued edges
    edge_pulses(7, 5);
    chk("mid_pending", req[7], 1'b1);
    pulse_claim(7);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    chk("mid_reset_req", req[7], 1'b0);
    pulse_complete(7);
    repeat (6) tick();
    chk("mid_abandoned", req[7], 1'b0);

    // Randomized traffic on all sources, including the reserved one
    for (int c = 0; c < 400; c++) begin
      irq_in   = irq_in ^ ($urandom() & $urandom() & $urandom());
      claim    = (exp_req & $urandom()) | ($urandom() & $urandom() & $urandom());
      complete = $urandom() & $urandom();
      reset    = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0; claim = '0; complete = '0;
    tick();
    chk("src0_req", req[0], 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired assertions=%0d failures=%0d", n_assert, n_fail);
    $fatal(1);
  end

endmodule
`default_nettype wire
